seq_controller: RTL and testbench

Multi-cycle stage sequencer for the Y86-64 SEQ processor. It walks each instruction through fetch, decode, execute, memory, writeback and PC update, one stage per state. It holds in fetch and memory on the instruction-memory and data-memory handshakes, and generates the per-stage write strobes (CC, register file, PC). It tracks the Y86 status code and stops the machine on halt or on an address or instruction exception.

---
 rtl/seq_controller.sv | 155 +++++++++++++++
 tb/tb_seq_controller.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_controller.sv
// Y86-64 SEQ stage sequencer: walks each instruction through fetch..PC update,
// holds on memory handshakes, drives per-stage strobes and tracks the status code.
module seq_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             imem_error,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             decode_en,
    output logic             execute_en,
    output logic             cc_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [3:0]       icode_q,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StPcUpd,
        StHalt
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       icode_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_access, mem_write, writes_reg;

    // Opcode classes, decoded from the latched opcode only.
    always_comb begin
        mem_access = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        mem_write  = icode_q inside {4'h4, 4'h8, 4'hA};
        writes_reg = icode_q inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            icode_q   <= 4'h0;
            stat_q    <= StatAok;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            icode_q   <= icode_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        icode_d    = icode_q;
        stat_d     = stat_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        decode_en  = 1'b0;
        execute_en = 1'b0;
        cc_we      = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_error) begin
                    state_d = StHalt;
                    stat_d  = StatAdr;
                end else if (imem_ready) begin
                    if (icode > 4'hB || !instr_valid) begin
                        state_d = StHalt;
                        stat_d  = StatIns;
                    end else begin
                        icode_d = icode;
                        state_d = StDecode;
                    end
                end
            end
            StDecode: begin
                decode_en = 1'b1;
                state_d   = StExecute;
            end
            StExecute: begin
                execute_en = 1'b1;
                cc_we      = (icode_q == 4'h6);
                state_d    = StMemory;
            end
            StMemory: begin
                if (mem_access) begin
                    dmem_req = 1'b1;
                    dmem_we  = mem_write;
                    if (dmem_error) begin
                        state_d = StHalt;
                        stat_d  = StatAdr;
                    end else if (dmem_ready) begin
                        state_d = StWriteback;
                    end
                end else begin
                    state_d = StWriteback;
                end
            end
            StWriteback: begin
                reg_we  = writes_reg;
                state_d = StPcUpd;
            end
            StPcUpd: begin
                retired_d = retired_q + CNT_W'(1);
                if (icode_q == 4'h0) begin
                    state_d = StHalt;
                    stat_d  = StatHlt;
                end else begin
                    pc_we   = 1'b1;
                    state_d = StFetch;
                end
            end
            StHalt: begin
                busy = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed instruction table, randomized
// instruction stream against a per-instruction cycle model, and async-reset corner cases.
module tb_seq_controller;

    localparam int unsigned CNT_W = 32;

    localparam int BIreq = 8, BDreq = 7, BDwe = 6, BDec = 5, BExe = 4;
    localparam int BCc = 3, BReg = 2, BPc = 1, BBusy = 0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             imem_ready = 1'b0, imem_error = 1'b0, instr_valid = 1'b0;
    logic [3:0]       icode = 4'h0;
    logic             dmem_ready = 1'b0, dmem_error = 1'b0;
    logic             imem_req, dmem_req, dmem_we, decode_en, execute_en;
    logic             cc_we, reg_we, pc_we, busy;
    logic [3:0]       icode_q;
    logic [2:0]       stat;
    logic [CNT_W-1:0] retired;
    logic [8:0]       obs;

    seq_controller #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_ready  (imem_ready),
        .imem_error  (imem_error),
        .icode       (icode),
        .instr_valid (instr_valid),
        .dmem_ready  (dmem_ready),
        .dmem_error  (dmem_error),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .decode_en   (decode_en),
        .execute_en  (execute_en),
        .cc_we       (cc_we),
        .reg_we      (reg_we),
        .pc_we       (pc_we),
        .icode_q     (icode_q),
        .stat        (stat),
        .busy        (busy),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, dmem_req, dmem_we, decode_en, execute_en, cc_we, reg_we, pc_we, busy};

    typedef struct {
        logic [3:0] icode;
        bit         valid;
        int         iwait;
        bit         ierr;
        int         dwait;
        bit         derr;
    } desc_t;

    typedef struct {
        logic       ir, ie, iv, dr, de;
        logic [8:0] exp;
    } step_t;

    typedef struct {
        desc_t      d;
        int         cycles;
        logic [2:0] st;
        int         ret, cc, rg, pc, dreq, dwe;
    } dir_t;

    int          checks = 0;
    int          failures = 0;
    step_t       steps[$];
    logic [3:0]  cur_icode;
    int          n_cc, n_reg, n_pc, n_dreq, n_dwe;
    int          exp_ret;
    logic [3:0]  exp_icode;
    dir_t        tbl[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic rb();
        return ($urandom & 1) != 0;
    endfunction

    function automatic desc_t mkd(logic [3:0] ic, bit v, int iw, bit ie, int dw, bit de);
        desc_t d;
        d.icode = ic; d.valid = v; d.iwait = iw; d.ierr = ie; d.dwait = dw; d.derr = de;
        return d;
    endfunction

    function automatic dir_t mkt(desc_t d, int cyc, logic [2:0] st, int ret, int cc, int rg,
                                 int pc, int dreq, int dwe);
        dir_t t;
        t.d = d; t.cycles = cyc; t.st = st; t.ret = ret; t.cc = cc; t.rg = rg;
        t.pc = pc; t.dreq = dreq; t.dwe = dwe;
        return t;
    endfunction

    function automatic step_t blank(logic [8:0] e);
        step_t s;
        s.ir = rb(); s.ie = 1'b0; s.iv = rb(); s.dr = rb(); s.de = 1'b0; s.exp = e;
        return s;
    endfunction

    // Reference model: expands one instruction into its per-cycle stimulus and expected strobes.
    task automatic build(input desc_t d, output logic [2:0] st_after, output bit retires);
        step_t s;
        bit    acc;
        steps.delete();
        cur_icode = d.icode;
        st_after = 3'd1;
        retires = 1'b0;
        for (int k = 0; k <= d.iwait; k++) begin
            s = blank(9'b0);
            s.exp[BIreq] = 1'b1; s.exp[BBusy] = 1'b1;
            s.ir = 1'b0;
            if (k == d.iwait) begin
                if (d.ierr) begin
                    s.ie = 1'b1; s.ir = rb();
                end else begin
                    s.ir = 1'b1; s.iv = d.valid;
                end
            end
            steps.push_back(s);
        end
        if (d.ierr) begin st_after = 3'd3; return; end
        if (d.icode > 4'hB || !d.valid) begin st_after = 3'd4; return; end
        s = blank(9'b0); s.exp[BDec] = 1'b1; s.exp[BBusy] = 1'b1; steps.push_back(s);
        s = blank(9'b0); s.exp[BExe] = 1'b1; s.exp[BBusy] = 1'b1;
        s.exp[BCc] = (d.icode == 4'h6);
        steps.push_back(s);
        acc = d.icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        if (acc) begin
            for (int k = 0; k <= d.dwait; k++) begin
                s = blank(9'b0);
                s.exp[BDreq] = 1'b1; s.exp[BBusy] = 1'b1;
                s.exp[BDwe] = d.icode inside {4'h4, 4'h8, 4'hA};
                s.dr = 1'b0;
                if (k == d.dwait) begin
                    if (d.derr) begin s.de = 1'b1; s.dr = rb(); end
                    else s.dr = 1'b1;
                end
                steps.push_back(s);
            end
            if (d.derr) begin st_after = 3'd3; return; end
        end else begin
            s = blank(9'b0); s.exp[BBusy] = 1'b1; steps.push_back(s);
        end
        s = blank(9'b0); s.exp[BBusy] = 1'b1;
        s.exp[BReg] = d.icode inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
        steps.push_back(s);
        s = blank(9'b0); s.exp[BBusy] = 1'b1; s.exp[BPc] = (d.icode != 4'h0);
        steps.push_back(s);
        retires = 1'b1;
        if (d.icode == 4'h0) st_after = 3'd2;
    endtask

    task automatic clear_inputs();
        start = 1'b0; imem_ready = 1'b0; imem_error = 1'b0; instr_valid = 1'b0;
        dmem_ready = 1'b0; dmem_error = 1'b0;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("icode_q_at_fetch", 32'(icode_q), 32'(exp_icode));
                check("retired_at_fetch", retired, exp_ret);
                check("stat_running", 32'(stat), 32'd1);
            end
            check("cycle_strobes", 32'(obs), 32'(steps[i].exp));
            n_cc += int'(cc_we); n_reg += int'(reg_we); n_pc += int'(pc_we);
            n_dreq += int'(dmem_req); n_dwe += int'(dmem_we);
            start = 1'b0;
            icode = cur_icode;
            imem_ready = steps[i].ir; imem_error = steps[i].ie; instr_valid = steps[i].iv;
            dmem_ready = steps[i].dr; dmem_error = steps[i].de;
        end
    endtask

    // Ends on a negedge with the DUT idle and the reset values checked.
    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_strobes", 32'(obs), 32'd0);
        check("reset_stat", 32'(stat), 32'd1);
        check("reset_icode_q", 32'(icode_q), 32'd0);
        check("reset_retired", retired, 32'd0);
        exp_ret = 0;
        exp_icode = 4'h0;
    endtask

    task automatic halt_checks(input logic [2:0] st);
        @(negedge clk);
        clear_inputs();
        check("halt_strobes", 32'(obs), 32'd0);
        check("halt_stat", 32'(stat), 32'(st));
        check("halt_retired", retired, exp_ret);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("halt_ignores_start", 32'(obs), 32'd0);
        check("halt_stat_frozen", 32'(stat), 32'(st));
    endtask

    task automatic do_instr(input desc_t d, output logic [2:0] st_after);
        bit ret;
        build(d, st_after, ret);
        run_steps(steps.size());
        if (!d.ierr && d.icode <= 4'hB && d.valid) exp_icode = d.icode;
        if (ret) exp_ret += 1;
    endtask

    initial begin
        logic [2:0] st;
        desc_t      d;

        tbl[0]  = mkt(mkd(4'h1, 1, 0, 0, 0, 0), 6, 3'd1, 1, 0, 0, 1, 0, 0); // nop
        tbl[1]  = mkt(mkd(4'h6, 1, 0, 0, 0, 0), 6, 3'd1, 1, 1, 1, 1, 0, 0); // OPq
        tbl[2]  = mkt(mkd(4'h5, 1, 0, 0, 3, 0), 9, 3'd1, 1, 0, 1, 1, 4, 0); // mrmovq slow
        tbl[3]  = mkt(mkd(4'h4, 1, 2, 0, 1, 0), 9, 3'd1, 1, 0, 0, 1, 2, 2); // rmmovq slow fetch
        tbl[4]  = mkt(mkd(4'hA, 1, 0, 0, 0, 0), 6, 3'd1, 1, 0, 1, 1, 1, 1); // pushq
        tbl[5]  = mkt(mkd(4'h4, 1, 0, 0, 0, 1), 4, 3'd3, 0, 0, 0, 0, 1, 1); // rmmovq dmem fault
        tbl[6]  = mkt(mkd(4'hC, 1, 0, 0, 0, 0), 1, 3'd4, 0, 0, 0, 0, 0, 0); // bad opcode
        tbl[7]  = mkt(mkd(4'h0, 1, 0, 0, 0, 0), 6, 3'd2, 1, 0, 0, 0, 0, 0); // halt
        tbl[8]  = mkt(mkd(4'h3, 1, 1, 1, 0, 0), 2, 3'd3, 0, 0, 0, 0, 0, 0); // imem fault
        tbl[9]  = mkt(mkd(4'h2, 0, 0, 0, 0, 0), 1, 3'd4, 0, 0, 0, 0, 0, 0); // bad ifun
        tbl[10] = mkt(mkd(4'h7, 1, 0, 0, 0, 0), 6, 3'd1, 1, 0, 0, 1, 0, 0); // jXX
        tbl[11] = mkt(mkd(4'hB, 1, 0, 0, 2, 1), 6, 3'd3, 0, 0, 0, 0, 3, 0); // popq late fault

        exp_ret = 0;
        exp_icode = 4'h0;

        for (int t = 0; t < 12; t++) begin
            reset_dut();
            start = 1'b1;
            n_cc = 0; n_reg = 0; n_pc = 0; n_dreq = 0; n_dwe = 0;
            build(tbl[t].d, st, d.derr);
            check("dir_cycles", steps.size(), tbl[t].cycles);
            do_instr(tbl[t].d, st);
            check("dir_cc_count", n_cc, tbl[t].cc);
            check("dir_reg_count", n_reg, tbl[t].rg);
            check("dir_pc_count", n_pc, tbl[t].pc);
            check("dir_dreq_count", n_dreq, tbl[t].dreq);
            check("dir_dwe_count", n_dwe, tbl[t].dwe);
            if (tbl[t].st == 3'd1) begin
                @(negedge clk);
                clear_inputs();
                check("dir_refetch", 32'(obs), 32'h101);
                check("dir_retired", retired, tbl[t].ret);
                check("dir_icode_q", 32'(icode_q), 32'(tbl[t].d.icode));
            end else begin
                check("dir_retired_model", exp_ret, tbl[t].ret);
                halt_checks(tbl[t].st);
                check("dir_busy_halt", 32'(busy), 32'd0);
            end
        end

        // Randomized instruction stream; halting instructions restart via reset.
        reset_dut();
        start = 1'b1;
        for (int n = 0; n < 250; n++) begin
            d.icode = 4'($urandom % 12);
            if ($urandom % 30 == 0) d.icode = 4'(12 + $urandom % 4);
            d.valid = ($urandom % 40) != 0;
            d.iwait = int'($urandom % 3);
            d.ierr  = ($urandom % 40) == 0;
            d.dwait = int'($urandom % 4);
            d.derr  = ($urandom % 25) == 0;
            do_instr(d, st);
            if (st != 3'd1) begin
                halt_checks(st);
                reset_dut();
                start = 1'b1;
            end
        end
        @(negedge clk);
        clear_inputs();

        // Async reset while dmem_req is held: outputs clear without a clock edge.
        reset_dut();
        start = 1'b1;
        build(mkd(4'h5, 1, 0, 0, 10, 0), st, d.derr);
        run_steps(4);
        @(negedge clk);
        check("pre_reset_dmem_req", 32'(dmem_req), 32'd1);
        check("pre_reset_icode_q", 32'(icode_q), 32'h5);
        dmem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_strobes", 32'(obs), 32'd0);
        check("async_reset_icode_q", 32'(icode_q), 32'd0);
        check("async_reset_stat", 32'(stat), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("idle_after_reset", 32'(obs), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("refetch_after_reset", 32'(obs), 32'h101);
        check("retired_after_reset", retired, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
